// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing of the shared datapath.
// Stalls on memReady, flags illegal opcodes and counts retired instructions.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        aluZero,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        pcSel,
    output logic        branch,
    output logic        irWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        memToReg,
    output logic        aluSrc,
    output logic [1:0]  aluOp,
    output logic        illegal,
    output logic [31:0] instret
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t     state;
    logic [6:0] opReg;
    logic       retire;
    logic       op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_EXEC:  retire = (opReg == OP_BEQ);
            S_MEM:   retire = (opReg == OP_STORE) && memReady;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            opReg   <= 7'd0;
            illegal <= 1'b0;
            instret <= 32'd0;
        end else begin
            if (retire)
                instret <= instret + 32'd1;
            case (state)
                S_FETCH: begin
                    if (memReady)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    opReg <= opcode;
                    if (op_legal) begin
                        state <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (opReg)
                        OP_R, OP_I:         state <= S_WB;
                        OP_LOAD, OP_STORE:  state <= S_MEM;
                        default:            state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (memReady)
                        state <= (opReg == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded combinationally and forced low while rst is held.
    always_comb begin
        pcWrite  = 1'b0;
        pcSel    = 1'b0;
        branch   = 1'b0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        memToReg = 1'b0;
        aluSrc   = 1'b0;
        aluOp    = 2'b00;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    irWrite = memReady;
                end
                S_DECODE: begin
                    pcWrite = !op_legal;
                end
                S_EXEC: begin
                    case (opReg)
                        OP_R: aluOp = 2'b10;
                        OP_I: begin
                            aluSrc = 1'b1;
                            aluOp  = 2'b11;
                        end
                        OP_LOAD, OP_STORE: aluSrc = 1'b1;
                        OP_BEQ: begin
                            aluOp   = 2'b01;
                            branch  = 1'b1;
                            pcWrite = 1'b1;
                            pcSel   = aluZero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (opReg == OP_LOAD) begin
                        memRead = 1'b1;
                    end else begin
                        memWrite = 1'b1;
                        pcWrite  = memReady;
                    end
                end
                S_WB: begin
                    regWrite = 1'b1;
                    memToReg = (opReg == OP_LOAD);
                    pcWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors and counters.
module tb_multicycle_ctrl;
    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        aluZero;
    logic        memReady;
    logic        pcWrite;
    logic        pcSel;
    logic        branch;
    logic        irWrite;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        memToReg;
    logic        aluSrc;
    logic [1:0]  aluOp;
    logic        illegal;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    // {pcWrite,pcSel,branch,irWrite,memRead,memWrite,regWrite,memToReg,aluSrc,aluOp}
    logic [10:0] outs;
    assign outs = {pcWrite, pcSel, branch, irWrite, memRead, memWrite,
                   regWrite, memToReg, aluSrc, aluOp};

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [10:0] E_FETCH  = 11'b00011000000;
    localparam logic [10:0] E_FWAIT  = 11'b00001000000;
    localparam logic [10:0] E_NONE   = 11'b00000000000;
    localparam logic [10:0] E_DILL   = 11'b10000000000;
    localparam logic [10:0] E_XR     = 11'b00000000010;
    localparam logic [10:0] E_XLS    = 11'b00000000100;
    localparam logic [10:0] E_XBT    = 11'b11100000001;
    localparam logic [10:0] E_XBN    = 11'b10100000001;
    localparam logic [10:0] E_MLD    = 11'b00001000000;
    localparam logic [10:0] E_MST    = 11'b10000100000;
    localparam logic [10:0] E_WBR    = 11'b10000010000;
    localparam logic [10:0] E_WBL    = 11'b10000011000;

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .aluZero  (aluZero),
        .memReady (memReady),
        .pcWrite  (pcWrite),
        .pcSel    (pcSel),
        .branch   (branch),
        .irWrite  (irWrite),
        .memRead  (memRead),
        .memWrite (memWrite),
        .regWrite (regWrite),
        .memToReg (memToReg),
        .aluSrc   (aluSrc),
        .aluOp    (aluOp),
        .illegal  (illegal),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stim bits: {keep opcode, memReady, aluZero}; opcode becomes junk when keep=0
    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (outs !== E_NONE) begin
            errors++;
            $display("FAIL reset_outs got %b exp %b", outs, E_NONE);
        end
        checks++;
        if (instret !== 32'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got %0d/%b exp 0/0", instret, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_r(input logic [31:0] exp_ret);
        logic [2:0]  st [4];
        logic [10:0] ex [4];
        st = '{3'b110, 3'b110, 3'b010, 3'b010};
        ex = '{E_FETCH, E_NONE, E_XR, E_WBR};
        for (int i = 0; i < 4; i++) begin
            opcode   = st[i][2] ? OP_R : OP_BAD;
            memReady = st[i][1];
            aluZero  = st[i][0];
            #1;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL r_type cyc %0d got %b exp %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_ret) begin
            errors++;
            $display("FAIL r_instret got %0d exp %0d", instret, exp_ret);
        end
    endtask

    task automatic test_beq();
        logic [2:0]  st [6];
        logic [10:0] ex [6];
        st = '{3'b111, 3'b110, 3'b011, 3'b111, 3'b110, 3'b010};
        ex = '{E_FETCH, E_NONE, E_XBT, E_FETCH, E_NONE, E_XBN};
        for (int i = 0; i < 6; i++) begin
            opcode   = st[i][2] ? OP_BEQ : OP_BAD;
            memReady = st[i][1];
            aluZero  = st[i][0];
            #1;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL beq cyc %0d got %b exp %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 32'd3) begin
            errors++;
            $display("FAIL beq_instret got %0d exp 3", instret);
        end
    endtask

    task automatic test_load_stall();
        logic [2:0]  st [10];
        logic [10:0] ex [10];
        st = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
        ex = '{E_FWAIT, E_FWAIT, E_FETCH, E_NONE, E_XLS,
               E_MLD, E_MLD, E_MLD, E_MLD, E_WBL};
        for (int i = 0; i < 10; i++) begin
            opcode   = st[i][2] ? OP_LOAD : OP_BAD;
            memReady = st[i][1];
            aluZero  = st[i][0];
            #1;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL load cyc %0d got %b exp %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 32'd4) begin
            errors++;
            $display("FAIL load_instret got %0d exp 4", instret);
        end
    endtask

    task automatic test_store();
        logic [2:0]  st [4];
        logic [10:0] ex [4];
        st = '{3'b110, 3'b110, 3'b010, 3'b010};
        ex = '{E_FETCH, E_NONE, E_XLS, E_MST};
        for (int i = 0; i < 4; i++) begin
            opcode   = st[i][2] ? OP_STORE : OP_BAD;
            memReady = st[i][1];
            aluZero  = st[i][0];
            #1;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL store cyc %0d got %b exp %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 32'd5) begin
            errors++;
            $display("FAIL store_instret got %0d exp 5", instret);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] ex [2];
        ex = '{E_FETCH, E_DILL};
        opcode   = OP_BAD;
        memReady = 1'b1;
        aluZero  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== ex[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal cyc %0d got %b/%b exp %b/0",
                         i, outs, illegal, ex[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (illegal !== 1'b1 || instret !== 32'd5) begin
            errors++;
            $display("FAIL illegal_after got %b/%0d exp 1/5", illegal, instret);
        end
        test_r(32'd6);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky got %b exp 1", illegal);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0]  st [4];
        logic [10:0] ex [4];
        st = '{3'b110, 3'b110, 3'b010, 3'b000};
        ex = '{E_FETCH, E_NONE, E_XLS, E_MLD};
        for (int i = 0; i < 4; i++) begin
            opcode   = st[i][2] ? OP_LOAD : OP_BAD;
            memReady = st[i][1];
            aluZero  = st[i][0];
            #1;
            checks++;
            if (outs !== ex[i]) begin
                errors++;
                $display("FAIL rmid cyc %0d got %b exp %b", i, outs, ex[i]);
            end
            if (i < 3)
                @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== E_NONE || instret !== 32'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL rmid_rst got %b/%0d/%b exp %b/0/0",
                     outs, instret, illegal, E_NONE);
        end
        @(negedge clk);
        memReady = 1'b1;
        #1;
        checks++;
        if (outs !== E_NONE) begin
            errors++;
            $display("FAIL rmid_hold got %b exp %b", outs, E_NONE);
        end
        @(negedge clk);
        rst      = 1'b0;
        memReady = 1'b0;
        #1;
        checks++;
        if (outs !== E_FWAIT) begin
            errors++;
            $display("FAIL rmid_fetch got %b exp %b", outs, E_FWAIT);
        end
        @(negedge clk);
        test_r(32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 7'd0;
        aluZero  = 1'b0;
        memReady = 1'b0;
        test_reset();
        test_r(32'd1);
        test_beq();
        test_load_stall();
        test_store();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
